// File: rtl/my_counter.sv
// my_counter: modulo-(MAX_COUNT+1) up/down counter.
// It has a synchronous active-high reset and a clamped parallel load.
// tc is a combinational terminal-count flag. It is high in the cycle
// before the count wraps.
// Optional feature: define MY_COUNTER_GRAY_OUT_EN to add output qg.
// qg is a registered Gray-coded copy of the count and updates on the
// same edge as qd.
module my_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qd,
  output logic             tc
`ifdef MY_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] qg
`endif
);

  // Terminal value as a WIDTH-bit constant, so comparisons need no width casts.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] qd_next;
  logic             at_top;
  logic             at_bottom;

  assign at_top    = (qd == MAX_Q);
  assign at_bottom = (qd == '0);

  // A load above the terminal value is clamped, so qd never leaves 0..MAX_COUNT.
  always_comb begin
    load_clamped = load_val;
    if (load_val > MAX_Q) begin
      load_clamped = MAX_Q;
    end
  end

  // Next count below reset: load beats enable, and enable beats hold.
  // The wrap is explicit, so a full-range MAX_COUNT also works.
  always_comb begin
    qd_next = qd;
    if (load) begin
      qd_next = load_clamped;
    end else if (en) begin
      if (up) begin
        qd_next = at_top ? '0 : (qd + WIDTH'(1));
      end else begin
        qd_next = at_bottom ? MAX_Q : (qd - WIDTH'(1));
      end
    end
  end

  // Count register; reset takes precedence over everything on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      qd <= '0;
    end else begin
      qd <= qd_next;
    end
  end

  // tc is high only while enabled and sitting on the value the next step wraps from.
  always_comb begin
    tc = en & ((up & at_top) | (~up & at_bottom));
  end

`ifdef MY_COUNTER_GRAY_OUT_EN
  // Gray copy is encoded from the next count so it lands on the same edge as qd.
  always_ff @(posedge clk) begin
    if (rst) begin
      qg <= '0;
    end else begin
      qg <= qd_next ^ (qd_next >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_my_counter.sv
// Scoreboard bench for my_counter.
// Stimulus pushes the hand-computed tc for the current cycle and the
// qd expected after the edge. One monitor per DUT pops entries on the
// falling edge and compares them.
// dut_a uses the defaults (WIDTH 4, MAX_COUNT 15).
// dut_b uses WIDTH 4, MAX_COUNT 9.
module tb_my_counter;

  typedef struct {
    logic       etc;
    logic [3:0] eqd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, load_a = 1'b0;
  logic [3:0] lv_a = '0;
  logic [3:0] qd_a;
  logic       tc_a;
  logic       rst_b = 1'b0, en_b = 1'b0, up_b = 1'b0, load_b = 1'b0;
  logic [3:0] lv_b = '0;
  logic [3:0] qd_b;
  logic       tc_b;
`ifdef MY_COUNTER_GRAY_OUT_EN
  logic [3:0] qg_a;
  logic [3:0] qg_b;
`endif

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_vectors = 0;
  int   n_compares = 0;
  int   n_miscompares = 0;

  int gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int up_seq[17]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
  int down_seq[17] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};
  int b_seq[10]    = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

  my_counter #(.WIDTH(4), .MAX_COUNT(15)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(lv_a), .qd(qd_a), .tc(tc_a)
`ifdef MY_COUNTER_GRAY_OUT_EN
    , .qg(qg_a)
`endif
  );

  my_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
    .load_val(lv_b), .qd(qd_b), .tc(tc_b)
`ifdef MY_COUNTER_GRAY_OUT_EN
    , .qg(qg_b)
`endif
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Compare one value against its expected value and print a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compares++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one vector into the chosen DUT just after a rising edge.
  // Push the expected tc for this cycle and the expected qd after the next edge.
  task automatic applyStimulus(input int sel, input logic r, input logic l, input logic [3:0] lv,
                               input logic e, input logic u, input logic etc, input int eqd);
    exp_t x;
    @(posedge clk);
    #1;
    if (sel == 0) begin
      rst_a = r; load_a = l; lv_a = lv; en_a = e; up_a = u;
    end else begin
      rst_b = r; load_b = l; lv_b = lv; en_b = e; up_b = u;
    end
    x.etc = etc;
    x.eqd = 4'(eqd);
    if (sel == 0) sb_a.push_back(x);
    else          sb_b.push_back(x);
    n_vectors++;
  endtask

  // Monitor for dut_a.
  // On each falling edge with a pending entry, check tc for this cycle.
  // Also check qd and qg against the previous entry's post-edge value.
  initial begin
    exp_t  x;
    logic  have_prev;
    int    prev_qd;
    have_prev = 1'b0;
    prev_qd   = 0;
    forever begin
      @(negedge clk);
      if (sb_a.size() > 0) begin
        x = sb_a.pop_front();
        if (have_prev) begin
          checkOutput("a_qd", int'(qd_a), prev_qd);
`ifdef MY_COUNTER_GRAY_OUT_EN
          checkOutput("a_qg", int'(qg_a), gray_tab[prev_qd]);
`endif
        end
        checkOutput("a_tc", int'(tc_a), int'(x.etc));
        prev_qd   = int'(x.eqd);
        have_prev = 1'b1;
      end
    end
  end

  // Monitor for dut_b; same scheme as dut_a.
  initial begin
    exp_t  x;
    logic  have_prev;
    int    prev_qd;
    have_prev = 1'b0;
    prev_qd   = 0;
    forever begin
      @(negedge clk);
      if (sb_b.size() > 0) begin
        x = sb_b.pop_front();
        if (have_prev) begin
          checkOutput("b_qd", int'(qd_b), prev_qd);
`ifdef MY_COUNTER_GRAY_OUT_EN
          checkOutput("b_qg", int'(qg_b), gray_tab[prev_qd]);
`endif
        end
        checkOutput("b_tc", int'(tc_b), int'(x.etc));
        prev_qd   = int'(x.eqd);
        have_prev = 1'b1;
      end
    end
  end

  // Directed stimulus.
  // Argument order: sel, rst, load, load_val, en, up, expected tc, expected qd after the edge.
  initial begin
    int budget;

    // dut_a: reset, then count up 17 steps; tc only while qd is 15.
    applyStimulus(0, 1, 0, 4'd0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 4'd0, 1, 1, (i == 15), up_seq[i]);

    // Reset, then count down 17 steps; tc only while qd is 0.
    applyStimulus(0, 1, 0, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 4'd0, 1, 0, (i == 0 || i == 16), down_seq[i]);

    // Load 5, then load 3 with en high: load wins. Then en low: hold with tc low.
    applyStimulus(0, 0, 1, 4'd5, 0, 1, 0, 5);
    applyStimulus(0, 0, 1, 4'd3, 1, 1, 0, 3);
    applyStimulus(0, 0, 0, 4'd0, 0, 1, 0, 3);

    // At 15 with en low, tc stays low. Then step down, step up, and wrap up.
    applyStimulus(0, 0, 1, 4'd15, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 4'd0, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 4'd0, 1, 0, 0, 14);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 0, 15);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 1, 0);

    // Count from 7, then rst together with load and en: reset wins. Then resume.
    applyStimulus(0, 0, 1, 4'd7, 0, 1, 0, 7);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 0, 8);
    applyStimulus(0, 1, 1, 4'd3, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 0, 1);

    // Reset mid-count, then count down: 0 wraps to 15 on the first step.
    applyStimulus(0, 1, 0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 4'd0, 1, 0, 1, 15);
    applyStimulus(0, 0, 0, 4'd0, 0, 0, 0, 15);

    // dut_b (MAX_COUNT 9): reset, then count up 0..9 and wrap to 0.
    applyStimulus(1, 1, 0, 4'd0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 4'd0, 1, 1, (i == 9), b_seq[i]);

    // Load 12 clamps to 9. Then step down, load 0, and wrap down to 9.
    applyStimulus(1, 0, 1, 4'd12, 0, 1, 0, 9);
    applyStimulus(1, 0, 0, 4'd0, 1, 0, 0, 8);
    applyStimulus(1, 0, 1, 4'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, 9);

    // Load 15 also clamps to 9. The trailing hold vector flushes the last qd check.
    applyStimulus(1, 0, 1, 4'd15, 0, 1, 0, 9);
    applyStimulus(1, 0, 0, 4'd0, 0, 1, 0, 9);

    // Give the monitors a bounded number of cycles to drain both queues.
    budget = 0;
    while ((sb_a.size() > 0 || sb_b.size() > 0) && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    if (sb_a.size() > 0 || sb_b.size() > 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", sb_a.size() + sb_b.size());
    end

    $display("[TB] %0d comparisons made", n_compares);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
